// File: rtl/sequenciador_instrucoes.sv
// rtl/sequenciador_instrucoes.sv - fetch/execute sequencer with tick divider
// Owns pc, ir and regA; drives the shared RAM port and hands ir to the ULA.
module sequenciador_instrucoes #(
  parameter int TICK_DIV = 10000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  output logic       rd,
  output logic       we,
  output logic [3:0] endMem,
  output logic [7:0] dataInMem,
  input  logic [7:0] dataOutMem,
  output logic [3:0] ulaOp,
  output logic [3:0] ulaOperando,
  input  logic [7:0] regSaidaULA,
  output logic [7:0] regA,
  output logic [3:0] pc,
  output logic [7:0] ir,
  output logic       halted,
  output logic [2:0] estado
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_STORE = 4'hC;
  localparam logic [3:0] OP_LOAD  = 4'hD;
  localparam logic [3:0] OP_JUMP  = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    S_INIT       = 3'd0,
    S_FETCH      = 3'd1,
    S_FETCH_WAIT = 3'd2,
    S_EXEC       = 3'd3,
    S_LOAD_WAIT  = 3'd4,
    S_HALT       = 3'd5
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [3:0]    pc_q;
  logic [7:0]    ir_q;
  logic [7:0]    rega_q;
  logic          tick;
  logic [3:0]    opcode;
  logic [3:0]    operand;
  logic          is_alu;

  assign opcode  = ir_q[7:4];
  assign operand = ir_q[3:0];
  assign is_alu  = (opcode != OP_NOP) && (opcode < OP_STORE);

  // A tick is only consumed on an edge where enable is still high.
  assign tick = enable && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (enable) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      pc_q    <= 4'h0;
      ir_q    <= 8'h00;
      rega_q  <= 8'h00;
    end else begin
      cnt_q <= cnt_d;
      if (tick) begin
        case (state_q)
          S_INIT:  state_q <= S_FETCH;
          S_FETCH: state_q <= S_FETCH_WAIT;
          S_FETCH_WAIT: begin
            ir_q    <= dataOutMem;
            pc_q    <= pc_q + 4'd1;
            state_q <= S_EXEC;
          end
          S_EXEC: begin
            if (is_alu) begin
              rega_q <= regSaidaULA;
            end
            if (opcode == OP_JUMP) begin
              pc_q <= operand;
            end
            if (opcode == OP_LOAD) begin
              state_q <= S_LOAD_WAIT;
            end else if (opcode == OP_HALT) begin
              state_q <= S_HALT;
            end else begin
              state_q <= S_FETCH;
            end
          end
          S_LOAD_WAIT: begin
            rega_q  <= dataOutMem;
            state_q <= S_FETCH;
          end
          S_HALT:  state_q <= S_HALT;
          default: state_q <= S_INIT;
        endcase
      end
    end
  end

  // Strobes decode straight from state so reset drops them without a clock edge.
  always_comb begin
    rd     = 1'b0;
    we     = 1'b0;
    endMem = 4'h0;
    case (state_q)
      S_FETCH: begin
        rd     = 1'b1;
        endMem = pc_q;
      end
      S_FETCH_WAIT: endMem = pc_q;
      S_EXEC: begin
        endMem = operand;
        rd     = (opcode == OP_LOAD);
        we     = (opcode == OP_STORE);
      end
      S_LOAD_WAIT: endMem = operand;
      default: ;
    endcase
  end

  assign dataInMem   = rega_q;
  assign ulaOp       = opcode;
  assign ulaOperando = operand;
  assign regA        = rega_q;
  assign pc          = pc_q;
  assign ir          = ir_q;
  assign halted      = (state_q == S_HALT);
  assign estado      = state_q;

endmodule
